// File: rtl/led_row_scan_ctrl.sv
// Row scanner for the 8x8 LED matrix.
// Latches a 64-cell frame in a one-cycle LOAD window, then walks rows 0..7.
// Each row gets a blanking gap (all off) followed by a lit interval.
// Every output is a register that is updated together with the state.
module led_row_scan_ctrl #(
    parameter int ROW_TICKS   = 1000,
    parameter int BLANK_TICKS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic [63:0] cells,
    input  logic        frame_valid,
    output logic        frame_ready,
    output logic [2:0]  row_sel,
    output logic        row_ena,
    output logic [7:0]  cols,
    output logic        frame_done
);

    localparam int CNT_MAX = (ROW_TICKS > BLANK_TICKS)
                           ? ((ROW_TICKS > 2) ? ROW_TICKS : 2)
                           : ((BLANK_TICKS > 2) ? BLANK_TICKS : 2);
    localparam int CW = $clog2(CNT_MAX);

    // Terminal counts: the counter runs 0 .. N-1 within a state.
    localparam logic [CW-1:0] ROW_LAST   = CW'(ROW_TICKS - 1);
    localparam logic [CW-1:0] BLANK_LAST = (BLANK_TICKS > 0) ? CW'(BLANK_TICKS - 1) : '0;
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_BLANK = 2'd2,
        S_ON    = 2'd3
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [63:0]    r_frame;
    logic [63:0]    w_load_frame;

    // Column byte of row r within a frame: cell (r,c) = f[8*r+c].
    function automatic logic [7:0] row_bits(input logic [63:0] f, input logic [2:0] r);
        row_bits = f[{r, 3'b000} +: 8];
    endfunction

    // Frame that will be in effect after the LOAD cycle (new data or redisplay).
    assign w_load_frame = frame_valid ? cells : r_frame;

    // Scan FSM; outputs are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_frame     <= 64'd0;
            frame_ready <= 1'b0;
            row_sel     <= 3'd0;
            row_ena     <= 1'b0;
            cols        <= 8'd0;
            frame_done  <= 1'b0;
        end else begin
            frame_ready <= 1'b0;
            frame_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt   <= '0;
                    row_sel <= 3'd0;
                    row_ena <= 1'b0;
                    cols    <= 8'd0;
                    if (ena) begin
                        r_state     <= S_LOAD;
                        frame_ready <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    r_cnt   <= '0;
                    row_sel <= 3'd0;
                    if (!ena) begin
                        // Abort keeps the previously latched frame.
                        r_state <= S_IDLE;
                        row_ena <= 1'b0;
                        cols    <= 8'd0;
                    end else begin
                        r_frame <= w_load_frame;
                        if (BLANK_TICKS == 0) begin
                            r_state <= S_ON;
                            row_ena <= 1'b1;
                            cols    <= row_bits(w_load_frame, 3'd0);
                        end else begin
                            r_state <= S_BLANK;
                            row_ena <= 1'b0;
                            cols    <= 8'd0;
                        end
                    end
                end
                S_BLANK: begin
                    if (!ena) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        row_sel <= 3'd0;
                        row_ena <= 1'b0;
                        cols    <= 8'd0;
                    end else if (r_cnt == BLANK_LAST) begin
                        r_state <= S_ON;
                        r_cnt   <= '0;
                        row_ena <= 1'b1;
                        cols    <= row_bits(r_frame, row_sel);
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_ON: begin
                    if ((r_cnt == ROW_LAST) && (row_sel == 3'd7)) begin
                        // Completed frame: pulse done in the following LOAD/IDLE cycle.
                        r_cnt      <= '0;
                        row_sel    <= 3'd0;
                        row_ena    <= 1'b0;
                        cols       <= 8'd0;
                        frame_done <= 1'b1;
                        if (ena) begin
                            r_state     <= S_LOAD;
                            frame_ready <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (!ena) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        row_sel <= 3'd0;
                        row_ena <= 1'b0;
                        cols    <= 8'd0;
                    end else if (r_cnt == ROW_LAST) begin
                        r_cnt   <= '0;
                        row_sel <= row_sel + 3'd1;
                        if (BLANK_TICKS == 0) begin
                            r_state <= S_ON;
                            row_ena <= 1'b1;
                            cols    <= row_bits(r_frame, row_sel + 3'd1);
                        end else begin
                            r_state <= S_BLANK;
                            row_ena <= 1'b0;
                            cols    <= 8'd0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    row_sel <= 3'd0;
                    row_ena <= 1'b0;
                    cols    <= 8'd0;
                end
            endcase
        end
    end

endmodule
